// File: rtl/instr_fetch_initiator.sv
// -----------------------------------------------------------------------------
// instr_fetch_initiator
//   OBI-style instruction fetch initiator. Issues sequential word fetches over a
//   req/gnt/rvalid port, buffers responses in an in-order FIFO tagged with
//   their fetch address, and presents them as a valid/ready stream. Redirects
//   flush the FIFO and drop responses to requests already in flight.
//
//   Ports
//     clk_i, rst_ni                 clock, async active-low reset
//     fetch_enable_i                allow new requests
//     branch_i, branch_addr_i       one-cycle redirect strobe and target
//     instr_req_o/gnt_i/addr_o      OBI address phase
//     instr_rvalid_i/rdata_i        OBI response phase
//     fetch_valid_o/ready_i         instruction stream handshake
//     fetch_rdata_o/addr_o          head instruction and its address
//     fifo_push_o/pop_o             FIFO write/read strobes
//     fifo_read/write_pointer_o     FIFO pointers
//     protocol_err_o                sticky: rvalid with nothing outstanding
//
//   state | meaning
//   IDLE  | no request; waits for fetch_enable_i
//   RUN   | requests issued whenever a credit is available
//   STALL | request presented but not yet granted; req/addr frozen
// -----------------------------------------------------------------------------
module instr_fetch_initiator #(
  parameter logic [31:0] BOOT_ADDR       = 32'h80,
  parameter int          FIFO_DEPTH      = 2,
  parameter int          FIFO_ADDR_DEPTH = $clog2(FIFO_DEPTH),
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       fetch_enable_i,
  input  logic                       branch_i,
  input  logic [31:0]                branch_addr_i,
  output logic                       instr_req_o,
  input  logic                       instr_gnt_i,
  output logic [31:0]                instr_addr_o,
  input  logic                       instr_rvalid_i,
  input  logic [31:0]                instr_rdata_i,
  output logic                       fetch_valid_o,
  input  logic                       fetch_ready_i,
  output logic [31:0]                fetch_rdata_o,
  output logic [31:0]                fetch_addr_o,
  output logic                       fifo_push_o,
  output logic                       fifo_pop_o,
  output logic [FIFO_ADDR_DEPTH-1:0] fifo_read_pointer_o,
  output logic [FIFO_ADDR_DEPTH-1:0] fifo_write_pointer_o,
  output logic                       protocol_err_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int SUM_W = CNT_W + 1;
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int TAG_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  localparam logic [31:0]                BOOT_WORD = {BOOT_ADDR[31:2], 2'b00};
  localparam logic [FIFO_ADDR_DEPTH-1:0] FPTR_LAST = FIFO_ADDR_DEPTH'(FIFO_DEPTH - 1);
  localparam logic [FIFO_ADDR_DEPTH-1:0] FPTR_ONE  = FIFO_ADDR_DEPTH'(1);
  localparam logic [TAG_W-1:0]           TPTR_LAST = TAG_W'(MAX_OUTSTANDING - 1);
  localparam logic [TAG_W-1:0]           TPTR_ONE  = TAG_W'(1);
  localparam logic [CNT_W-1:0]           CNT_ONE   = CNT_W'(1);
  localparam logic [OUT_W-1:0]           OUT_ONE   = OUT_W'(1);
  localparam logic [OUT_W-1:0]           OUT_MAX   = OUT_W'(MAX_OUTSTANDING);
  localparam logic [SUM_W-1:0]           SUM_DEPTH = SUM_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [31:0]          addr_q, addr_d;
  logic [31:0]          pend_addr_q, pend_addr_d;
  logic                 pend_valid_q, pend_valid_d;
  logic [OUT_W-1:0]     out_q, out_d;
  logic [OUT_W-1:0]     disc_q, disc_d;
  logic                 err_q;

  logic [31:0]          tag_mem_q [MAX_OUTSTANDING];
  logic [TAG_W-1:0]     tag_wr_q, tag_rd_q;

  logic [31:0]          fifo_data_q [FIFO_DEPTH];
  logic [31:0]          fifo_tag_q  [FIFO_DEPTH];
  logic [FIFO_ADDR_DEPTH-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [31:0]          target;
  logic [SUM_W-1:0]     occupancy;
  logic                 credit;
  logic                 req_fire;
  logic                 rv_ok;
  logic                 rv_stray;
  logic                 push;
  logic                 pop;
  logic                 stall_drop;
  logic                 unused_bits;

  function automatic logic [FIFO_ADDR_DEPTH-1:0] fptr_inc(input logic [FIFO_ADDR_DEPTH-1:0] p);
    return (p == FPTR_LAST) ? '0 : p + FPTR_ONE;
  endfunction

  function automatic logic [TAG_W-1:0] tptr_inc(input logic [TAG_W-1:0] p);
    return (p == TPTR_LAST) ? '0 : p + TPTR_ONE;
  endfunction

  assign unused_bits = ^branch_addr_i[1:0];
  assign target      = {branch_addr_i[31:2], 2'b00};

  // Credit counts in-flight requests as if they already occupy the FIFO, so a
  // response always has room and rvalid never needs back-pressure.
  assign occupancy = SUM_W'(cnt_q) + SUM_W'(out_q);
  assign credit    = (occupancy < SUM_DEPTH) && (out_q < OUT_MAX);

  assign req_fire  = instr_req_o && instr_gnt_i;
  assign rv_ok     = instr_rvalid_i && (out_q != '0);
  assign rv_stray  = instr_rvalid_i && (out_q == '0);
  assign push      = rv_ok && (disc_q == '0) && !branch_i;
  assign pop       = fetch_valid_o && fetch_ready_i && !branch_i;

  // A request stalled across a redirect still fetches the old address; its
  // response is stale and must be dropped once it finally gets granted.
  assign stall_drop = (state_q == STALL) && instr_gnt_i && pend_valid_q && !branch_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    pend_addr_d  = pend_addr_q;
    pend_valid_d = pend_valid_q;
    instr_req_o  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fetch_enable_i) state_d = RUN;
        if (branch_i)       addr_d  = target;
      end
      RUN: begin
        instr_req_o = credit && fetch_enable_i;
        if (instr_req_o) begin
          if (instr_gnt_i) begin
            addr_d = branch_i ? target : addr_q + 32'd4;
          end else begin
            // Request is now committed; hold it and park any redirect.
            state_d = STALL;
            if (branch_i) begin
              pend_valid_d = 1'b1;
              pend_addr_d  = target;
            end
          end
        end else begin
          if (branch_i)        addr_d  = target;
          if (!fetch_enable_i) state_d = IDLE;
        end
      end
      STALL: begin
        instr_req_o = 1'b1;
        if (instr_gnt_i) begin
          state_d      = fetch_enable_i ? RUN : IDLE;
          pend_valid_d = 1'b0;
          if (branch_i)          addr_d = target;
          else if (pend_valid_q) addr_d = pend_addr_q;
          else                   addr_d = addr_q + 32'd4;
        end else if (branch_i) begin
          pend_valid_d = 1'b1;
          pend_addr_d  = target;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    out_d = out_q;
    if (req_fire) out_d = out_d + OUT_ONE;
    if (rv_ok)    out_d = out_d - OUT_ONE;

    disc_d = disc_q;
    if (branch_i) begin
      // Everything still in flight after this cycle belongs to the old path.
      disc_d = out_d;
    end else begin
      if (rv_ok && (disc_q != '0)) disc_d = disc_d - OUT_ONE;
      if (stall_drop)              disc_d = disc_d + OUT_ONE;
    end

    cnt_d = cnt_q;
    if (branch_i) begin
      cnt_d = '0;
    end else if (push && !pop) begin
      cnt_d = cnt_q + CNT_ONE;
    end else if (pop && !push) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q       <= BOOT_WORD;
      pend_addr_q  <= '0;
      pend_valid_q <= 1'b0;
      out_q        <= '0;
      disc_q       <= '0;
      err_q        <= 1'b0;
      tag_wr_q     <= '0;
      tag_rd_q     <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) tag_mem_q[i] <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_tag_q[i]  <= '0;
      end
    end else begin
      addr_q       <= addr_d;
      pend_addr_q  <= pend_addr_d;
      pend_valid_q <= pend_valid_d;
      out_q        <= out_d;
      disc_q       <= disc_d;
      cnt_q        <= cnt_d;
      if (rv_stray) err_q <= 1'b1;

      // Tag queue mirrors the outstanding requests, popped on every response
      // (kept or dropped) so it stays aligned with out_q.
      if (req_fire) begin
        tag_mem_q[tag_wr_q] <= addr_q;
        tag_wr_q            <= tptr_inc(tag_wr_q);
      end
      if (rv_ok) tag_rd_q <= tptr_inc(tag_rd_q);

      if (push) begin
        fifo_data_q[wr_ptr_q] <= instr_rdata_i;
        fifo_tag_q[wr_ptr_q]  <= tag_mem_q[tag_rd_q];
      end
      if (branch_i) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= fptr_inc(wr_ptr_q);
        if (pop)  rd_ptr_q <= fptr_inc(rd_ptr_q);
      end
    end
  end

  assign instr_addr_o         = addr_q;
  assign fetch_valid_o        = (cnt_q != '0);
  assign fetch_rdata_o        = fifo_data_q[rd_ptr_q];
  assign fetch_addr_o         = fifo_tag_q[rd_ptr_q];
  assign fifo_push_o          = push;
  assign fifo_pop_o           = pop;
  assign fifo_read_pointer_o  = rd_ptr_q;
  assign fifo_write_pointer_o = wr_ptr_q;
  assign protocol_err_o       = err_q;

endmodule
